cordic_shift_sequencer: RTL and testbench

Reader/controller for the synchronous shift-amount ROM (LUT_SHIFT) used by the CORDIC natural-logarithm datapath. On START it walks the ROM addresses 0..N_ITER-1. For each address it drives EN_ROM1/ADRS, waits out the ROM latency, and presents the returned shift amount to the CORDIC iteration stage under a valid/ack handshake. It sits between the log control FSM and the shift/add iteration datapath, replacing ad-hoc ROM addressing.

---
 rtl/cordic_shift_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cordic_shift_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_shift_sequencer.sv
// cordic_shift_sequencer
//   Walks the LUT_SHIFT ROM addresses 0..N_ITER-1 for the CORDIC log datapath.
//   It issues one ROM read per iteration, waits out the ROM latency and then
//   presents the returned shift amount to the iteration stage under a
//   valid/ack handshake.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-low reset
//   START      begin a sequence (sampled only in IDLE)
//   N_ITER     iteration count, latched on accepted START, saturated to 2**ADDR_W
//   EN_ROM1    ROM read enable, one pulse per iteration
//   ADRS       ROM address
//   O_D        ROM read data
//   SHIFT_AMT  registered shift amount of the presented iteration
//   ITER_IDX   index of the presented iteration
//   SHIFT_VLD  SHIFT_AMT / ITER_IDX valid
//   ACK        consumer accepts the presented shift amount
//   BUSY       high from accepted START until the sequence completes
//   DONE       one-cycle completion pulse
module cordic_shift_sequencer #(
  parameter int unsigned ROM_WIDTH = 5,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [ADDR_W:0]      N_ITER,
  output logic                 EN_ROM1,
  output logic [ADDR_W-1:0]    ADRS,
  input  logic [ROM_WIDTH-1:0] O_D,
  output logic [ROM_WIDTH-1:0] SHIFT_AMT,
  output logic [ADDR_W-1:0]    ITER_IDX,
  output logic                 SHIFT_VLD,
  input  logic                 ACK,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [1:0]      LAT_W   = 2'(ROM_LAT);

  state_t                 state_q, state_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]      adrs_q, adrs_d;
  logic                   en_q, en_d;
  logic [ROM_WIDTH-1:0]   amt_q, amt_d;
  logic                   vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic                   last_iter;

  assign last_iter = ({1'b0, idx_q} == (cnt_q - ONE_CNT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    adrs_d  = adrs_q;
    en_d    = 1'b0;
    amt_d   = amt_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          busy_d = 1'b1;
          cnt_d  = (N_ITER > MAX_CNT) ? MAX_CNT : N_ITER;
          if (N_ITER == '0) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
      end

      // Outputs are registered, so the read request decided here is seen by
      // the ROM during the first WAIT cycle; WAIT therefore spans ROM_LAT+1
      // edges before O_D is captured.
      S_FETCH: begin
        en_d    = 1'b1;
        adrs_d  = idx_q;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wcnt_q == LAT_W) begin
          amt_d   = O_D;
          vld_d   = 1'b1;
          state_d = S_PRESENT;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end

      S_PRESENT: begin
        if (ACK) begin
          vld_d = 1'b0;
          if (last_iter) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      adrs_q  <= '0;
      en_q    <= 1'b0;
      amt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      adrs_q  <= adrs_d;
      en_q    <= en_d;
      amt_q   <= amt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign EN_ROM1   = en_q;
  assign ADRS      = adrs_q;
  assign SHIFT_AMT = amt_q;
  assign ITER_IDX  = idx_q;
  assign SHIFT_VLD = vld_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_cordic_shift_sequencer.sv
module tb_cordic_shift_sequencer;

  typedef struct packed {
    logic [4:0] idx;
    logic [4:0] amt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] n_iter = '0;
  logic       en;
  logic [4:0] adrs;
  logic [4:0] o_d = '0;
  logic [4:0] amt;
  logic [4:0] idx;
  logic       vld;
  logic       ack = 1'b0;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic seen = 1'b0;

  exp_t       exp_q[$];
  logic [4:0] adrs_q[$];

  always #5 clk = ~clk;

  cordic_shift_sequencer #(
    .ROM_WIDTH(5),
    .ADDR_W(5),
    .ROM_LAT(1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .START(start),
    .N_ITER(n_iter),
    .EN_ROM1(en),
    .ADRS(adrs),
    .O_D(o_d),
    .SHIFT_AMT(amt),
    .ITER_IDX(idx),
    .SHIFT_VLD(vld),
    .ACK(ack),
    .BUSY(busy),
    .DONE(done)
  );

  // ROM model: registered read, data = address + 1 (mod 32)
  always @(posedge clk) begin
    if (en) o_d <= adrs + 5'd1;
  end

  // Scoreboard monitor: ROM addresses and presented (index, amount) pairs
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] ea;
    if (en) begin
      en_cnt++;
      checks++;
      if (adrs_q.size() == 0) begin
        failures++;
        $display("FAIL adrs_unexpected: got ADRS=%0d, no read expected", adrs);
      end else begin
        ea = adrs_q.pop_front();
        if (adrs !== ea) begin
          failures++;
          $display("FAIL adrs: got %0d expected %0d", adrs, ea);
        end
      end
    end
    if (done) done_cnt++;
    if (vld && !seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL present_unexpected: got idx=%0d amt=%0d, none expected", idx, amt);
      end else begin
        e = exp_q.pop_front();
        if (idx !== e.idx || amt !== e.amt) begin
          failures++;
          $display("FAIL present: got idx=%0d amt=%0d expected idx=%0d amt=%0d",
                   idx, amt, e.idx, e.amt);
        end
      end
    end
    seen = vld;
  end

  task automatic push_seq(input int n);
    int m;
    m = (n > 32) ? 32 : n;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back('{idx: 5'(i), amt: 5'((i + 1) % 32)});
      adrs_q.push_back(5'(i));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({en, adrs, amt, idx, vld, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_state: got en=%b adrs=%0d amt=%0d idx=%0d vld=%b busy=%b done=%b expected all 0",
               en, adrs, amt, idx, vld, busy, done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int cyc;
    en_cnt = 0; done_cnt = 0;
    ack = 1'b1; n_iter = 6'd3;
    push_seq(3);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0;
    while (!vld && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles expected 3", lat);
    end
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || en_cnt !== 3 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_end: got done=%0d en=%0d busy=%b left=%0d expected 1 3 0 0",
               done_cnt, en_cnt, busy, exp_q.size());
    end
  endtask

  task automatic test_hold();
    int cyc;
    en_cnt = 0; done_cnt = 0;
    ack = 1'b0; n_iter = 6'd2;
    push_seq(2);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!vld && cyc < 20) begin @(negedge clk); cyc++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (vld !== 1'b1 || amt !== 5'd1 || idx !== 5'd0 || en !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d got vld=%b amt=%0d idx=%0d en=%b expected 1 1 0 0",
                 k, vld, amt, idx, en);
      end
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (vld !== 1'b0 || en !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack_edge: got vld=%b en=%b expected 0 0", vld, en);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      failures++;
      $display("FAIL hold_refetch: got en=%b expected 1", en);
    end
    ack = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || en_cnt !== 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL hold_end: got done=%0d en=%0d left=%0d expected 1 2 0",
               done_cnt, en_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero();
    en_cnt = 0; done_cnt = 0;
    ack = 1'b1; n_iter = 6'd0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_first: got busy=%b done=%b expected 1 1", busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_second: got busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en_cnt !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL zero_counts: got en=%0d done=%0d expected 0 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    en_cnt = 0; done_cnt = 0;
    ack = 1'b1; n_iter = 6'd40;
    push_seq(40);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || en_cnt !== 32 || exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sat_end: got done=%0d en=%0d left=%0d busy=%b expected 1 32 0 0",
               done_cnt, en_cnt, exp_q.size(), busy);
    end
    checks++;
    if (amt !== 5'd0 || idx !== 5'd31) begin
      failures++;
      $display("FAIL sat_last: got amt=%0d idx=%0d expected 0 31", amt, idx);
    end
  endtask

  task automatic test_ignore();
    int cyc;
    en_cnt = 0; done_cnt = 0;
    ack = 1'b0; n_iter = 6'd4;
    push_seq(4);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!en && cyc < 20) begin @(negedge clk); cyc++; end
    start = 1'b1; n_iter = 6'd9; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    checks++;
    if (vld !== 1'b0) begin
      failures++;
      $display("FAIL ignore_wait: got vld=%b expected 0", vld);
    end
    ack = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || en_cnt !== 4 || exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_end: got done=%0d en=%0d left=%0d busy=%b expected 1 4 0 0",
               done_cnt, en_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    en_cnt = 0; done_cnt = 0;
    ack = 1'b0; n_iter = 6'd4;
    push_seq(4);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!vld && cyc < 20) begin @(negedge clk); cyc++; end
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    cyc = 0;
    while (!vld && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (vld !== 1'b1 || idx !== 5'd1) begin
      failures++;
      $display("FAIL midrst_present: got vld=%b idx=%0d expected 1 1", vld, idx);
    end
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    checks++;
    if ({en, adrs, amt, idx, vld, busy, done} !== '0) begin
      failures++;
      $display("FAIL midrst_state: got en=%b adrs=%0d amt=%0d idx=%0d vld=%b busy=%b done=%b expected all 0",
               en, adrs, amt, idx, vld, busy, done);
    end
    exp_q.delete();
    adrs_q.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: got done=%0d busy=%b expected 0 0", done_cnt, busy);
    end
    en_cnt = 0;
    ack = 1'b1; n_iter = 6'd1;
    push_seq(1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || en_cnt !== 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_restart: got done=%0d en=%0d left=%0d expected 1 1 0",
               done_cnt, en_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_zero();
    test_saturate();
    test_ignore();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
